mem_except_unit: RTL and testbench

Memory-stage exception unit for the pipeline. It replaces the combinational memory-stage exception stub. It detects size-aware misalignment, qualifies MMU page/access faults and breakpoints, and priority-encodes them into a RISC-V cause. It then captures cause, faulting value and PC into a trap register, which is held under a valid/ack handshake with the trap handler. It also emits a one-cycle pipeline flush and keeps a saturating exception count.

---
 rtl/mem_except_unit.sv | 141 ++++++++++++++
 tb/tb_mem_except_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_except_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_except_unit
// Purpose  : Memory-stage exception detection, RISC-V cause priority encode,
//            trap capture held under a valid/ack handshake, one-cycle flush
//            and a saturating accepted-exception counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_except_unit #(
    parameter int N             = 64,
    parameter int CNT_W         = 8,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [N-1:0]     DM_addr,
    input  logic [1:0]       memOp,
    input  logic [1:0]       memSize,
    input  logic [N-1:0]     pc,
    input  logic             brk,
    input  logic             pf_read,
    input  logic             pf_write,
    input  logic             af_read,
    input  logic             af_write,
    output logic [6:0]       exceptSignal,
    output logic             trap_valid,
    input  logic             trap_ack,
    output logic [3:0]       trap_cause,
    output logic [N-1:0]     trap_tval,
    output logic [N-1:0]     trap_epc,
    output logic             flush,
    output logic [CNT_W-1:0] exc_count
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [0:0]       r_state;
    logic [3:0]       r_cause;
    logic [N-1:0]     r_tval;
    logic [N-1:0]     r_epc;
    logic             r_flush;
    logic [CNT_W-1:0] r_count;

    logic [2:0]   w_mask;
    logic         w_mis;
    logic         w_is_store;
    logic         w_is_load;
    logic         w_any;
    logic         w_capture;
    logic [3:0]   w_cause;
    logic [N-1:0] w_tval;

    // Low-address-bit mask for the access size; byte accesses never misalign
    always_comb begin
        w_mask = 3'b000;
        case (memSize)
            2'd0:    w_mask = 3'b000;
            2'd1:    w_mask = 3'b001;
            2'd2:    w_mask = 3'b011;
            default: w_mask = 3'b111;
        endcase
    end

    assign w_mis      = (MISALIGN_TRAP != 0) && (|(DM_addr[2:0] & w_mask));
    // An AMO sets both op bits and is reported purely as a store
    assign w_is_store = memOp[1];
    assign w_is_load  = memOp[0] & ~memOp[1];

    assign exceptSignal = mem_valid ? {brk,
                                       pf_write & w_is_store,
                                       pf_read  & w_is_load,
                                       af_write & w_is_store,
                                       w_mis    & w_is_store,
                                       af_read  & w_is_load,
                                       w_mis    & w_is_load} : 7'b0;

    assign w_any     = |exceptSignal;
    assign w_capture = (r_state == S_IDLE) && w_any;

    // Highest-priority pending exception selects the cause code
    always_comb begin
        w_cause = 4'd0;
        if (exceptSignal[6])      w_cause = 4'd3;
        else if (exceptSignal[2]) w_cause = 4'd6;
        else if (exceptSignal[0]) w_cause = 4'd4;
        else if (exceptSignal[5]) w_cause = 4'd15;
        else if (exceptSignal[4]) w_cause = 4'd13;
        else if (exceptSignal[3]) w_cause = 4'd7;
        else if (exceptSignal[1]) w_cause = 4'd5;
    end

    // Breakpoints report the PC; every data fault reports the address
    assign w_tval = exceptSignal[6] ? pc : DM_addr;

    // Trap FSM, capture registers, flush pulse and saturating counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cause <= 4'd0;
            r_tval  <= '0;
            r_epc   <= '0;
            r_flush <= 1'b0;
            r_count <= '0;
        end else begin
            r_flush <= w_capture;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state <= S_PENDING;
                        r_cause <= w_cause;
                        r_tval  <= w_tval;
                        r_epc   <= pc;
                        if (r_count != c_CNT_MAX) begin
                            r_count <= r_count + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    // Exceptions arriving while a trap is held are dropped
                    if (trap_ack) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign trap_valid = (r_state == S_PENDING);
    assign trap_cause = r_cause;
    assign trap_tval  = r_tval;
    assign trap_epc   = r_epc;
    assign flush      = r_flush;
    assign exc_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_except_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_except_unit
// Purpose  : Directed self-checking bench for mem_except_unit. Three
//            instances share stimulus: default parameters, misalign trapping
//            disabled, and a 2-bit exception counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_except_unit;

    localparam int N = 64;
    localparam logic [N-1:0] c_PC0 = 64'h8000_0000_0000_1000;
    localparam logic [N-1:0] c_PC1 = 64'h8000_0000_0000_2004;
    localparam logic [N-1:0] c_PC2 = 64'h8000_0000_0000_3008;
    localparam logic [N-1:0] c_PC3 = 64'h8000_0000_0000_400C;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_valid;
    logic [N-1:0] DM_addr;
    logic [1:0]   memOp;
    logic [1:0]   memSize;
    logic [N-1:0] pc;
    logic         brk, pf_read, pf_write, af_read, af_write;
    logic         trap_ack;

    logic [6:0]   exc_0, exc_1, exc_2;
    logic         tv_0, tv_1, tv_2;
    logic [3:0]   cause_0, cause_1, cause_2;
    logic [N-1:0] tval_0, tval_1, tval_2;
    logic [N-1:0] epc_0, epc_1, epc_2;
    logic         flush_0, flush_1, flush_2;
    logic [7:0]   cnt_0, cnt_1;
    logic [1:0]   cnt_2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_except_unit #(.N(N), .CNT_W(8), .MISALIGN_TRAP(1)) u_dut0 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .DM_addr(DM_addr),
        .memOp(memOp), .memSize(memSize), .pc(pc), .brk(brk),
        .pf_read(pf_read), .pf_write(pf_write), .af_read(af_read), .af_write(af_write),
        .exceptSignal(exc_0), .trap_valid(tv_0), .trap_ack(trap_ack),
        .trap_cause(cause_0), .trap_tval(tval_0), .trap_epc(epc_0),
        .flush(flush_0), .exc_count(cnt_0)
    );

    mem_except_unit #(.N(N), .CNT_W(8), .MISALIGN_TRAP(0)) u_dut1 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .DM_addr(DM_addr),
        .memOp(memOp), .memSize(memSize), .pc(pc), .brk(brk),
        .pf_read(pf_read), .pf_write(pf_write), .af_read(af_read), .af_write(af_write),
        .exceptSignal(exc_1), .trap_valid(tv_1), .trap_ack(trap_ack),
        .trap_cause(cause_1), .trap_tval(tval_1), .trap_epc(epc_1),
        .flush(flush_1), .exc_count(cnt_1)
    );

    mem_except_unit #(.N(N), .CNT_W(2), .MISALIGN_TRAP(1)) u_dut2 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .DM_addr(DM_addr),
        .memOp(memOp), .memSize(memSize), .pc(pc), .brk(brk),
        .pf_read(pf_read), .pf_write(pf_write), .af_read(af_read), .af_write(af_write),
        .exceptSignal(exc_2), .trap_valid(tv_2), .trap_ack(trap_ack),
        .trap_cause(cause_2), .trap_tval(tval_2), .trap_epc(epc_2),
        .flush(flush_2), .exc_count(cnt_2)
    );

    // One comparison: counts it and reports any difference
    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid = 1'b0; DM_addr = '0; memOp = 2'd0; memSize = 2'd0; pc = '0;
        brk = 1'b0; pf_read = 1'b0; pf_write = 1'b0; af_read = 1'b0; af_write = 1'b0;
        trap_ack = 1'b0;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        clear_inputs();
        reset = 1'b1;
        tick();
        chk("reset_valid", {63'b0, tv_0}, 64'd0);
        chk("reset_flush", {63'b0, flush_0}, 64'd0);
        chk("reset_cause", {60'b0, cause_0}, 64'd0);
        chk("reset_count", {56'b0, cnt_0}, 64'd0);
        reset = 1'b0;

        // Misaligned word load: traps on DUT0, suppressed on DUT1
        mem_valid = 1'b1; memOp = 2'd1; DM_addr = 64'h2; memSize = 2'd2; pc = c_PC0;
        #1;
        chk("mis_word_exc", {57'b0, exc_0}, 64'b0000001);
        chk("mis_off_exc", {57'b0, exc_1}, 64'd0);
        tick();
        chk("mis_valid", {63'b0, tv_0}, 64'd1);
        chk("mis_cause", {60'b0, cause_0}, 64'd4);
        chk("mis_tval", tval_0, 64'h2);
        chk("mis_epc", epc_0, c_PC0);
        chk("mis_flush_on", {63'b0, flush_0}, 64'd1);
        chk("mis_count", {56'b0, cnt_0}, 64'd1);
        chk("mis_off_valid", {63'b0, tv_1}, 64'd0);
        mem_valid = 1'b0;
        tick();
        chk("mis_flush_off", {63'b0, flush_0}, 64'd0);
        chk("mis_held", {63'b0, tv_0}, 64'd1);
        trap_ack = 1'b1;
        tick();
        chk("mis_ack", {63'b0, tv_0}, 64'd0);
        trap_ack = 1'b0;

        // Half and byte accesses at the same address are aligned
        mem_valid = 1'b1; memSize = 2'd1;
        #1;
        chk("mis_half_exc", {57'b0, exc_0}, 64'd0);
        memSize = 2'd0;
        #1;
        chk("mis_byte_exc", {57'b0, exc_0}, 64'd0);
        mem_valid = 1'b0;

        // AMO with misalign + store faults: misalign wins
        mem_valid = 1'b1; memOp = 2'd3; DM_addr = 64'h7; memSize = 2'd3;
        pf_write = 1'b1; af_write = 1'b1; pc = c_PC1;
        #1;
        chk("amo_exc", {57'b0, exc_0}, 64'b0101100);
        tick();
        chk("amo_cause", {60'b0, cause_0}, 64'd6);
        chk("amo_tval", tval_0, 64'h7);
        mem_valid = 1'b0; trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;

        // Same with breakpoint: breakpoint wins and reports the PC
        brk = 1'b1; mem_valid = 1'b1;
        #1;
        chk("brk_exc", {57'b0, exc_0}, 64'b1101100);
        tick();
        chk("brk_cause", {60'b0, cause_0}, 64'd3);
        chk("brk_tval", tval_0, c_PC1);
        chk("brk_count", {56'b0, cnt_0}, 64'd3);
        clear_inputs();

        // Asynchronous reset between edges while the trap is pending
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_valid", {63'b0, tv_0}, 64'd0);
        chk("rst_cause", {60'b0, cause_0}, 64'd0);
        chk("rst_tval", tval_0, 64'd0);
        chk("rst_epc", epc_0, 64'd0);
        chk("rst_count", {56'b0, cnt_0}, 64'd0);
        mem_valid = 1'b1; brk = 1'b1;
        #1;
        chk("rst_exc_comb", {57'b0, exc_0}, 64'b1000000);
        mem_valid = 1'b0; brk = 1'b0;
        tick();
        reset = 1'b0;

        // Handshake: load page fault captured, later store fault held off
        mem_valid = 1'b1; memOp = 2'd1; pf_read = 1'b1; DM_addr = 64'h100;
        memSize = 2'd3; pc = c_PC2;
        #1;
        chk("lpf_exc", {57'b0, exc_0}, 64'b0010000);
        tick();
        chk("lpf_cause", {60'b0, cause_0}, 64'd13);
        chk("lpf_count", {56'b0, cnt_0}, 64'd1);
        pf_read = 1'b0; memOp = 2'd2; af_write = 1'b1; DM_addr = 64'h208; pc = c_PC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_cause", {60'b0, cause_0}, 64'd13);
            chk("hold_tval", tval_0, 64'h100);
            chk("hold_epc", epc_0, c_PC2);
            chk("hold_count", {56'b0, cnt_0}, 64'd1);
            chk("hold_valid", {63'b0, tv_0}, 64'd1);
        end
        trap_ack = 1'b1;
        tick();
        chk("ack_valid", {63'b0, tv_0}, 64'd0);
        chk("ack_drop_cause", {60'b0, cause_0}, 64'd13);
        trap_ack = 1'b0;
        tick();
        chk("saf_valid", {63'b0, tv_0}, 64'd1);
        chk("saf_cause", {60'b0, cause_0}, 64'd7);
        chk("saf_tval", tval_0, 64'h208);
        chk("saf_epc", epc_0, c_PC3);
        chk("saf_count", {56'b0, cnt_0}, 64'd2);
        chk("saf_flush", {63'b0, flush_0}, 64'd1);
        clear_inputs();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;

        // Gating: everything asserted but mem_valid low
        brk = 1'b1; pf_read = 1'b1; pf_write = 1'b1; af_read = 1'b1; af_write = 1'b1;
        memOp = 2'd3; DM_addr = 64'h7; memSize = 2'd3;
        #1;
        chk("gate_exc", {57'b0, exc_0}, 64'd0);
        tick();
        chk("gate_valid", {63'b0, tv_0}, 64'd0);
        chk("gate_count", {56'b0, cnt_0}, 64'd2);
        clear_inputs();

        // Saturation on the 2-bit counter instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1'b1; brk = 1'b1;
            tick();
            chk("sat_count", {62'b0, cnt_2}, {62'b0, sat_exp[i]});
            mem_valid = 1'b0; brk = 1'b0; trap_ack = 1'b1;
            tick();
            trap_ack = 1'b0;
        end
        chk("nosat_count", {56'b0, cnt_0}, 64'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
